// File: rtl/bcd_time_counter_if.sv
// Button and display-side signals of the BCD time counter, bundled with
// master (button/display side) and slave (counter core) modports.
interface bcd_time_counter_if;
    logic        btn_mode;
    logic        btn_inc;
    logic [23:0] time_bcd;
    logic        sec_tick;
    logic        set_hour;
    logic        set_min;
    logic [5:0]  blank_mask;

    modport master (
        output btn_mode, btn_inc,
        input  time_bcd, sec_tick, set_hour, set_min, blank_mask
    );

    modport slave (
        input  btn_mode, btn_inc,
        output time_bcd, sec_tick, set_hour, set_min, blank_mask
    );
endinterface

// File: rtl/bcd_time_counter.sv
// 24-hour hh:mm:ss BCD timekeeper with a 1 Hz prescaler and two-button set mode.
// Optional 2 Hz digit blinking in the set states is built when BCD_TIME_COUNTER_BLINK_EN is defined.
module bcd_time_counter #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    bcd_time_counter_if.slave  bus
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    // Sexagesimal two-digit BCD increment; bit 8 is the carry out of 59.
    function automatic logic [8:0] inc_sexa(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                return {1'b1, 8'h00};
            end else begin
                return {1'b0, v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            return {1'b0, v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23) begin
            return 8'h00;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_hours;
    logic [7:0]      r_mins;
    logic [7:0]      r_secs;
    logic            r_sec_tick;
    logic            r_set_hour;
    logic            r_set_min;

    logic [8:0]      w_sec_next;
    logic [8:0]      w_min_next;
    logic [7:0]      w_hour_next;

    assign w_sec_next  = inc_sexa(r_secs);
    assign w_min_next  = inc_sexa(r_mins);
    assign w_hour_next = inc_hour(r_hours);

    // Mode FSM, prescaler and time registers; a mode press always wins over an increment or tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_presc    <= '0;
            r_hours    <= 8'h00;
            r_mins     <= 8'h00;
            r_secs     <= 8'h00;
            r_sec_tick <= 1'b0;
            r_set_hour <= 1'b0;
            r_set_min  <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.btn_mode) begin
                        r_state    <= ST_SET_HOUR;
                        r_set_hour <= 1'b1;
                        r_presc    <= '0;
                    end else if (r_presc == PRESC_LAST) begin
                        r_presc    <= '0;
                        r_sec_tick <= 1'b1;
                        r_secs     <= w_sec_next[7:0];
                        if (w_sec_next[8]) begin
                            r_mins <= w_min_next[7:0];
                            if (w_min_next[8]) begin
                                r_hours <= w_hour_next;
                            end
                        end
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
                ST_SET_HOUR: begin
                    if (bus.btn_mode) begin
                        r_state    <= ST_SET_MIN;
                        r_set_hour <= 1'b0;
                        r_set_min  <= 1'b1;
                    end else if (bus.btn_inc) begin
                        r_hours <= w_hour_next;
                    end
                end
                ST_SET_MIN: begin
                    if (bus.btn_mode) begin
                        // Seconds restart from zero so the edited minute begins cleanly.
                        r_state   <= ST_RUN;
                        r_set_min <= 1'b0;
                        r_secs    <= 8'h00;
                        r_presc   <= '0;
                    end else if (bus.btn_inc) begin
                        r_mins <= w_min_next[7:0];
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_presc    <= '0;
                    r_set_hour <= 1'b0;
                    r_set_min  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.time_bcd = {r_hours, r_mins, r_secs};
    assign bus.sec_tick = r_sec_tick;
    assign bus.set_hour = r_set_hour;
    assign bus.set_min  = r_set_min;

`ifdef BCD_TIME_COUNTER_BLINK_EN
    localparam int QTR = CLK_FREQ / 4;
    localparam int BW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(QTR - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [5:0]    r_blank_mask;

    // Blink phase restarts visible on entry to a set state and after every edit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blank_mask  <= 6'b000000;
        end else if ((r_state == ST_RUN && !bus.btn_mode) ||
                     (r_state == ST_SET_MIN && bus.btn_mode)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blank_mask  <= 6'b000000;
        end else if (bus.btn_mode || bus.btn_inc) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_blank_mask  <= 6'b000000;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
            if (!r_blink_phase) begin
                r_blank_mask <= (r_state == ST_SET_HOUR) ? 6'b110000 : 6'b001100;
            end else begin
                r_blank_mask <= 6'b000000;
            end
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign bus.blank_mask = r_blank_mask;
`else
    assign bus.blank_mask = 6'b000000;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomized plus directed bench for bcd_time_counter, checked every cycle
// against a seconds-of-day reference model.
module tb_bcd_time_counter;

    localparam int F = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: plain hour/minute/second integers.
    int m_h, m_m, m_s;
    int m_mode;
    int m_pc;
    int m_k;
    bit m_tick;

    bcd_time_counter_if bus ();

    bcd_time_counter #(.CLK_FREQ(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_bcd();
        logic [23:0] v;
        v = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
        return v;
    endfunction

    function automatic logic [5:0] exp_mask();
`ifdef BCD_TIME_COUNTER_BLINK_EN
        bit ph;
        ph = ((m_k / (F / 4)) % 2) == 1;
        if (m_mode == 1 && ph) return 6'b110000;
        else if (m_mode == 2 && ph) return 6'b001100;
        else return 6'b000000;
`else
        return 6'b000000;
`endif
    endfunction

    function automatic logic legal_time(input logic [23:0] t);
        int hh, mm, ss;
        if (t[23:20] > 4'd2 || t[19:16] > 4'd9 || t[15:12] > 4'd5 ||
            t[11:8] > 4'd9 || t[7:4] > 4'd5 || t[3:0] > 4'd9) return 1'b0;
        hh = int'(t[23:20]) * 10 + int'(t[19:16]);
        mm = int'(t[15:12]) * 10 + int'(t[11:8]);
        ss = int'(t[7:4]) * 10 + int'(t[3:0]);
        return (hh < 24 && mm < 60 && ss < 60) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_step(input bit r, input bit bm, input bit bi);
        int t;
        m_tick = 1'b0;
        if (r) begin
            m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_pc = 0; m_k = 0;
        end else if (m_mode == 0) begin
            if (bm) begin
                m_mode = 1; m_pc = 0; m_k = 0;
            end else if (m_pc == F - 1) begin
                m_pc = 0;
                m_tick = 1'b1;
                t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600;
                m_m = (t / 60) % 60;
                m_s = t % 60;
            end else begin
                m_pc++;
            end
        end else if (m_mode == 1) begin
            if (bm) begin
                m_mode = 2; m_k = 0;
            end else if (bi) begin
                m_h = (m_h + 1) % 24; m_k = 0;
            end else begin
                m_k++;
            end
        end else begin
            if (bm) begin
                m_mode = 0; m_s = 0; m_pc = 0; m_k = 0;
            end else if (bi) begin
                m_m = (m_m + 1) % 60; m_k = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic check_all();
        check_val("time_bcd", 32'(bus.time_bcd), 32'(exp_bcd()));
        check_val("sec_tick", 32'(bus.sec_tick), 32'(m_tick));
        check_val("set_hour", 32'(bus.set_hour), 32'(m_mode == 1));
        check_val("set_min", 32'(bus.set_min), 32'(m_mode == 2));
        check_val("blank_mask", 32'(bus.blank_mask), 32'(exp_mask()));
    endtask

    task automatic cycle(input bit r, input bit bm, input bit bi);
        rst = r;
        bus.btn_mode = bm;
        bus.btn_inc = bi;
        @(posedge clk);
        model_step(r, bm, bi);
        #1;
        rst = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_pc = 0; m_k = 0; m_tick = 1'b0;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check_val("reset_time", 32'(bus.time_bcd), 32'h0);

        // Forty cycles of free running give ten seconds.
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b0);
        check_val("run40", 32'(bus.time_bcd), 32'h000010);

        // Preload 23:59 via set mode, then let seconds reach 59.
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59 * F; i++) cycle(1'b0, 1'b0, 1'b0);
        check_val("pre_wrap", 32'(bus.time_bcd), 32'h235959);
        for (int i = 0; i < F; i++) cycle(1'b0, 1'b0, 1'b0);
        check_val("day_wrap", 32'(bus.time_bcd), 32'h000000);

        // Step hours through a full day in SET_HOUR.
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check_val("hour_legal", 32'(legal_time(bus.time_bcd)), 32'h1);
        end
        check_val("hour_back_00", 32'(bus.time_bcd[23:16]), 32'h00);

        // Minutes wrap 59 -> 00 without touching hours.
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 1'b1);
        check_val("min_59", 32'(bus.time_bcd[15:8]), 32'h59);
        cycle(1'b0, 1'b0, 1'b1);
        check_val("min_wrap", 32'(bus.time_bcd[23:8]), 32'h0000);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < F - 1; i++) cycle(1'b0, 1'b0, 1'b0);
        check_val("no_early_tick", 32'(bus.sec_tick), 32'h0);
        cycle(1'b0, 1'b0, 1'b0);
        check_val("first_tick", 32'(bus.sec_tick), 32'h1);

        // Simultaneous mode and increment, then reset from SET_MIN.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check_val("both_set_min", 32'(bus.set_min), 32'h1);
        check_val("both_hours", 32'(bus.time_bcd[23:16]), 32'h01);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check_val("rst_mid_time", 32'(bus.time_bcd), 32'h0);
        check_val("rst_mid_flags", 32'({bus.set_hour, bus.set_min, bus.sec_tick, bus.blank_mask}), 32'h0);

        // Random button and reset traffic.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 599) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            check_val("rand_legal", 32'(legal_time(bus.time_bcd)), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Timekeeping core of the clock design. Divides the system clock into a 1 Hz tick and advances a 24-hour hh:mm:ss count held as six BCD digits. Provides a two-button set mode for hours and minutes. Its `time_bcd` output feeds the downstream 24H/AM-PM display-format stage directly, so it is always a valid 24-hour BCD time from 00:00:00 to 23:59:59.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock cycles per second. Must be ≥ 4 and divisible by 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  one-cycle pulse, already debounced; advances the mode FSM.
- `btn_inc`  in  1  one-cycle pulse, already debounced; increments the field being set.
- `time_bcd`  out  24  {h_tens, h_units, m_tens, m_units, s_tens, s_units}, 4 bits per digit; registered.
- `sec_tick`  out  1  registered one-cycle pulse in the same cycle `time_bcd` shows a newly advanced second.
- `set_hour`  out  1  high while in SET_HOUR.
- `set_min`  out  1  high while in SET_MIN.
- `blank_mask`  out  6  per-digit blank request for the display; bit 5 = h_tens … bit 0 = s_units.

## Operation
- **Reset state:**
  - `time_bcd` = 24'h000000.
  - `sec_tick`, `set_hour`, `set_min` and `blank_mask` = 0.
  - FSM in RUN; prescaler and blink counter at 0.
- **Prescaler:** counts 0..CLK_FREQ-1 in RUN and asserts an internal tick when the count equals CLK_FREQ-1, then wraps to 0. It is held at 0 in both set states.
- **Time advance (RUN, on tick):**
  - s_units increments 0..9. At 9 it wraps to 0 and carries into s_tens (0..5).
  - 59 s wraps to 00 and carries into minutes, with the same digit rules.
  - 59 min carries into hours.
  - Hours wrap 23→00, so 23:59:59 → 00:00:00.
  - Each digit stays within its legal BCD range; no other code is ever produced.
- **Mode FSM:** RUN --btn_mode--> SET_HOUR --btn_mode--> SET_MIN --btn_mode--> RUN.
  - `set_hour` = (state == SET_HOUR).
  - `set_min` = (state == SET_MIN).
- **Increment in SET_HOUR:** `btn_inc` increments hours by one, wrapping 23→00 (09→10, 19→20).
- **Increment in SET_MIN:** `btn_inc` increments minutes by one, wrapping 59→00 with no carry into hours.
- **Increment in RUN:** `btn_inc` is ignored.
- **Time held during setting:** no seconds advance in either set state.
- **Leaving SET_MIN for RUN:** seconds are cleared to 00 and the prescaler restarts at 0, so the first tick comes CLK_FREQ cycles after exit.
- **Simultaneous `btn_mode` and `btn_inc`:** the mode transition is taken and the increment is dropped.
- **Reset mid-operation:** from any state, reset returns everything to the reset state on the next edge. Partial edits are lost.

## Timing
- A tick detected at edge N produces the new `time_bcd` and `sec_tick` = 1 after edge N; `sec_tick` is high for exactly one cycle.
- A `btn_inc` sampled at edge N is visible on `time_bcd` after edge N; latency is 1 cycle.
- A `btn_mode` sampled at edge N updates `set_hour`/`set_min` after edge N.
- `sec_tick` is never asserted in SET_HOUR or SET_MIN.
- The second period is exactly CLK_FREQ cycles in steady RUN.

## Configuration
- Macro: `BCD_TIME_COUNTER_BLINK_EN`.
- **With the macro defined:**
  - A blink counter runs in the set states, toggling a phase bit every CLK_FREQ/4 cycles, i.e. 2 Hz blink.
  - Phase is 0 (digits visible) on entry to each set state; the counter is cleared on every `btn_inc`, so the digits stay visible right after an edit.
  - `blank_mask[5:4]` = phase in SET_HOUR; `blank_mask[3:2]` = phase in SET_MIN; all other bits are 0.
  - `blank_mask` = 0 in RUN.
- **Without the macro:** no blink counter is built, and `blank_mask` is constant 0.

## Test plan
- CLK_FREQ=4, reset, run 40 cycles → `time_bcd` = 24'h000010, with `sec_tick` pulses spaced 4 cycles apart starting 4 cycles after reset release.
- Preload to 23:59:59 via set mode (hours 23, minutes 59) plus ticks, then one tick → `time_bcd` = 24'h000000.
- In SET_HOUR from 00, send 24 `btn_inc` pulses → hours step 00..23 then return to 00, never showing A–F in any digit.
- In SET_MIN at 59, one `btn_inc` → minutes 00 with hours unchanged. Then `btn_mode` → RUN with seconds 00, and the first `sec_tick` comes 4 cycles later.
- Same-cycle `btn_mode` and `btn_inc` in SET_HOUR → state SET_MIN, hours unchanged. Assert `rst` mid-SET_MIN → next cycle `time_bcd` = 0, RUN, all flags 0.
- With `BCD_TIME_COUNTER_BLINK_EN` and CLK_FREQ=8, enter SET_HOUR → `blank_mask` = 6'b000000 for 2 cycles, then 6'b110000 for 2 cycles, alternating. Without the macro, `blank_mask` stays 0 throughout.
